// File: rtl/gorev_cerceve_gonderici_pkg.sv
// Shared constants and helpers for the task frame transmitter.
//   - Header byte constants (first three fixed bytes of every frame).
//   - Task byte mapping: task n -> 8'h{n}0.
//   - State encoding for the transmitter FSM.
package gorev_cerceve_gonderici_pkg;

    localparam logic [7:0] CERCEVE_B0 = 8'hBA;
    localparam logic [7:0] CERCEVE_B1 = 8'hCD;
    localparam logic [7:0] CERCEVE_B2 = 8'hA0;

    typedef enum logic [1:0] {
        StBosta  = 2'd0,
        StBaslik = 2'd1,
        StYuk    = 2'd2
    } durum_e;

    // Fourth header byte carries the task number in the upper nibble.
    function automatic logic [7:0] gorev_bayti(input logic [2:0] gorev);
        return {1'b0, gorev, 4'h0};
    endfunction

    // Tasks 0 and 7 are not defined on the accelerator side.
    function automatic logic gorev_gecerli(input logic [2:0] gorev);
        return (gorev != 3'd0) && (gorev != 3'd7);
    endfunction

    function automatic logic [7:0] baslik_bayti(input logic [1:0] indeks,
                                                 input logic [2:0] gorev);
        logic [7:0] bayt;
        case (indeks)
            2'd0:    bayt = CERCEVE_B0;
            2'd1:    bayt = CERCEVE_B1;
            2'd2:    bayt = CERCEVE_B2;
            default: bayt = gorev_bayti(gorev);
        endcase
        return bayt;
    endfunction

endpackage

// File: rtl/gorev_cerceve_gonderici.sv
// Host-side frame transmitter for the accelerator byte command stream.
// On an accepted start it emits the 4-byte header BA, CD, A0, {task,4'h0}
// and then passes exactly `uzunluk_i` payload bytes from the source stream
// straight through to the accelerator.
//
// Ports:
//   clk_i, rstn_i             clock, async active-low reset
//   basla_i, gorev_i,         start request, task number (1..6), payload
//   uzunluk_i                 length; all sampled only while idle
//   k_veri_i, k_gecerli_i,    payload source stream (valid/ready)
//   k_hazir_o
//   h_veri_o, h_gecerli_o,    output stream to the accelerator (valid/ready)
//   h_hazir_i
//   mesgul_o                  frame in progress
//   bitti_o                   one-cycle pulse after the final handshake
//   hata_o                    one-cycle pulse after a start with invalid task
module gorev_cerceve_gonderici
    import gorev_cerceve_gonderici_pkg::*;
#(
    parameter int unsigned LEN_BIT = 24
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               basla_i,
    input  logic [2:0]         gorev_i,
    input  logic [LEN_BIT-1:0] uzunluk_i,
    input  logic [7:0]         k_veri_i,
    input  logic               k_gecerli_i,
    output logic               k_hazir_o,
    output logic [7:0]         h_veri_o,
    output logic               h_gecerli_o,
    input  logic               h_hazir_i,
    output logic               mesgul_o,
    output logic               bitti_o,
    output logic               hata_o
);

    localparam logic [LEN_BIT-1:0] KALAN_BIR = LEN_BIT'(1);

    durum_e             durum_q, durum_d;
    logic [2:0]         gorev_q, gorev_d;
    logic [LEN_BIT-1:0] kalan_q, kalan_d;
    logic [1:0]         indeks_q, indeks_d;
    logic               bitti_q, bitti_d;
    logic               hata_q, hata_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q  <= StBosta;
            gorev_q  <= 3'd0;
            kalan_q  <= '0;
            indeks_q <= 2'd0;
            bitti_q  <= 1'b0;
            hata_q   <= 1'b0;
        end else begin
            durum_q  <= durum_d;
            gorev_q  <= gorev_d;
            kalan_q  <= kalan_d;
            indeks_q <= indeks_d;
            bitti_q  <= bitti_d;
            hata_q   <= hata_d;
        end
    end

    always_comb begin
        durum_d     = durum_q;
        gorev_d     = gorev_q;
        kalan_d     = kalan_q;
        indeks_d    = indeks_q;
        bitti_d     = 1'b0;
        hata_d      = 1'b0;
        h_veri_o    = 8'h00;
        h_gecerli_o = 1'b0;
        k_hazir_o   = 1'b0;
        mesgul_o    = 1'b0;

        case (durum_q)
            StBosta: begin
                if (basla_i) begin
                    if (gorev_gecerli(gorev_i)) begin
                        gorev_d  = gorev_i;
                        kalan_d  = uzunluk_i;
                        indeks_d = 2'd0;
                        durum_d  = StBaslik;
                    end else begin
                        hata_d = 1'b1;
                    end
                end
            end

            StBaslik: begin
                mesgul_o    = 1'b1;
                // Byte is a function of registered state only, so it stays
                // stable for as long as the accelerator stalls.
                h_veri_o    = baslik_bayti(indeks_q, gorev_q);
                h_gecerli_o = 1'b1;
                if (h_hazir_i) begin
                    indeks_d = indeks_q + 2'd1;
                    if (indeks_q == 2'd3) begin
                        if (kalan_q != '0) begin
                            durum_d = StYuk;
                        end else begin
                            durum_d = StBosta;
                            bitti_d = 1'b1;
                        end
                    end
                end
            end

            StYuk: begin
                mesgul_o    = 1'b1;
                h_veri_o    = k_veri_i;
                h_gecerli_o = k_gecerli_i;
                k_hazir_o   = h_hazir_i;
                if (k_gecerli_i && h_hazir_i) begin
                    kalan_d = kalan_q - KALAN_BIR;
                    // Leave on the last byte so the counter never wraps.
                    if (kalan_q == KALAN_BIR) begin
                        durum_d = StBosta;
                        bitti_d = 1'b1;
                    end
                end
            end

            default: begin
                durum_d = StBosta;
            end
        endcase
    end

    assign bitti_o = bitti_q;
    assign hata_o  = hata_q;

endmodule

// File: doc/gorev_cerceve_gonderici.md
# gorev_cerceve_gonderici

Host-side frame transmitter for the accelerator's byte command stream. On a start pulse it emits the four-byte task header 0xBA, 0xCD, 0xA0, {task, 4'h0}, then forwards exactly `uzunluk_i` payload (JPEG) bytes from a source stream. Its output is a valid/ready byte stream that plugs directly into the accelerator input (`h_veri_i`/`h_gecerli_i`/`h_hazir_o`). It is the producing end of that protocol.

## Interface
- `LEN_BIT`, default 24: width of the payload byte counter.
- `clk_i`  in  1  system clock; all state changes on its rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `basla_i`  in  1  start request; sampled only in BOSTA.
- `gorev_i`  in  3  task number, valid values 1..6; sampled with `basla_i`.
- `uzunluk_i`  in  LEN_BIT  payload byte count; sampled with `basla_i`; 0 is legal.
- `k_veri_i`  in  8  payload byte from source.
- `k_gecerli_i`  in  1  payload byte valid.
- `k_hazir_o`  out  1  payload byte accepted.
- `h_veri_o`  out  8  output byte to accelerator.
- `h_gecerli_o`  out  1  output byte valid.
- `h_hazir_i`  in  1  accelerator ready.
- `mesgul_o`  out  1  frame in progress.
- `bitti_o`  out  1  one-cycle pulse: frame complete.
- `hata_o`  out  1  one-cycle pulse: start rejected, invalid task.

## Operation
- States: BOSTA, BASLIK, YUK.
- BOSTA: `h_gecerli_o`=0, `k_hazir_o`=0, `mesgul_o`=0.
  - `basla_i`=1 with `gorev_i` in 1..6 latches task and length, clears the 2-bit header index, and moves to BASLIK.
  - `basla_i`=1 with `gorev_i` of 0 or 7 pulses `hata_o` next cycle and stays in BOSTA.
- BASLIK: `h_veri_o` = header[index], where header = BA, CD, A0, {task,4'h0}; `h_gecerli_o`=1, `k_hazir_o`=0.
  - The index advances on each `h_gecerli_o && h_hazir_i`.
  - After index 3 is accepted: go to YUK if latched length ≠ 0; otherwise go to BOSTA and pulse `bitti_o`.
- YUK: combinational pass-through. `h_veri_o`=`k_veri_i`, `h_gecerli_o`=`k_gecerli_i`, `k_hazir_o`=`h_hazir_i`.
  - Each transfer (`k_gecerli_i && h_hazir_i`) decrements the remaining count.
  - The transfer at count 1 returns to BOSTA and pulses `bitti_o`.
- `mesgul_o` = 1 in BASLIK and YUK.
- `basla_i` in BASLIK/YUK is ignored; no queuing.
- Source bytes offered outside YUK are not consumed.
- The accelerator holds the task and streams until reset, so frames are one-shot per accelerator reset. The block itself accepts back-to-back starts.

## Timing
- Reset values: `h_veri_o`=0, `h_gecerli_o`=0, `k_hazir_o`=0, `mesgul_o`=0, `bitti_o`=0, `hata_o`=0. State = BOSTA, counters = 0.
- Reset asserted mid-frame abandons the frame immediately (async). No `bitti_o` pulse.
- Start latency: `basla_i` high in cycle N → 0xBA valid in cycle N+1.
- Header bytes are registered and held stable while `h_hazir_i`=0. The minimum header duration is 4 cycles.
- Payload has zero latency and full throughput: one byte per cycle when both sides are ready.
- `bitti_o`/`hata_o` are registered and high exactly one cycle: the cycle after the final handshake or the rejected start. In that cycle `mesgul_o`=0 and a new `basla_i` is accepted.
- Counter width rule: lengths up to 2^LEN_BIT−1. No wrap, since decrement stops at the last byte.

## Structure
- `sabitler.vh` gains:
  - header byte constants `CERCEVE_B0`=8'hBA, `CERCEVE_B1`=8'hCD, `CERCEVE_B2`=8'hA0;
  - task-byte mapping macro (task n → 8'h{n}0);
  - state encodings for BOSTA/BASLIK/YUK.
- Single module; header byte selection and the length counter are inline. No sub-module.

## Test plan
- Task 3, length 2, sink always ready, bytes 0x11, 0x22 → output BA, CD, A0, 30, 11, 22 on consecutive cycles; `bitti_o` one cycle after the 0x22 handshake.
- Task 1, length 0 → output BA, CD, A0, 10 only; `bitti_o` after the 4th byte; `k_hazir_o` never high.
- Task 7 start → no `h_gecerli_o`; `hata_o`=1 for exactly one cycle; `mesgul_o` stays 0.
- Task 6, length 3, `h_hazir_i` toggled 1/0 and `k_gecerli_i` gapped → header bytes held stable while stalled; exactly 3 payload bytes transferred, in order.
- `rstn_i` pulsed low during the 2nd payload byte of a length-5 frame → all outputs 0 immediately; next start emits a fresh BA header.
- `basla_i` held high during a frame → ignored. Start in the `bitti_o` cycle → BA appears on the next cycle.
